mem_port_arbiter: RTL and testbench

//  Shares the single-port unified memory between the pipeline's instruction-fetch (IF) and data (MEM-stage) ports.

---
 rtl/mem_port_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between IF and data ports; data first, IF forced in after MAX_D_STREAK data grants, hung memory aborted after TIMEOUT cycles.
// Request at edge N -> mem_req from N+1, ack at N+1+k -> ready pulse in N+2+k; requesters stall (req held) until their ready pulse.
module mem_port_arbiter #(
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stall_if,
    output logic        stall_mem,
    output logic        err_timeout
);
    localparam int SW = $clog2(MAX_D_STREAK + 1);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;

    state_t        state_q;
    logic [SW-1:0] streak_q, streak_d;
    logic [TW-1:0] timer_q;
    logic          mem_req_q, mem_we_q;
    logic [31:0]   mem_addr_q, mem_wdata_q;
    logic [3:0]    mem_be_q;
    logic          if_ready_q, d_ready_q, err_q;
    logic [31:0]   if_rdata_q, d_rdata_q;
    logic          data_wins;
    logic          done_now;
    logic [31:0]   rdata_cap;

    // Streak only counts data grants that overtook a waiting fetch.
    always_comb begin
        data_wins = d_req && !(if_req && streak_q == STREAK_MAX);
        streak_d  = '0;
        if (data_wins && if_req) begin
            streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + SW'(1);
        end
        done_now  = mem_ack || (timer_q == TIMER_LAST);
        rdata_cap = mem_ack ? mem_rdata : 32'h0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            streak_q    <= '0;
            timer_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            if_ready_q  <= 1'b0;
            d_ready_q   <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            if_ready_q <= 1'b0;
            d_ready_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (data_wins) begin
                        state_q     <= BUSY_D;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= d_we;
                        mem_addr_q  <= d_addr;
                        mem_wdata_q <= d_wdata;
                        mem_be_q    <= d_be;
                        streak_q    <= streak_d;
                    end else if (if_req) begin
                        state_q     <= BUSY_I;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= if_addr;
                        mem_wdata_q <= '0;
                        mem_be_q    <= 4'hF;
                        streak_q    <= '0;
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (done_now) begin
                        state_q   <= DONE;
                        mem_req_q <= 1'b0;
                        timer_q   <= '0;
                        if (!mem_ack) begin
                            err_q <= 1'b1;
                        end
                        if (state_q == BUSY_I) begin
                            if_ready_q <= 1'b1;
                            if_rdata_q <= rdata_cap;
                        end else begin
                            d_ready_q <= 1'b1;
                            d_rdata_q <= rdata_cap;
                        end
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_be      = mem_be_q;
    assign if_ready    = if_ready_q;
    assign if_rdata    = if_rdata_q;
    assign d_ready     = d_ready_q;
    assign d_rdata     = d_rdata_q;
    assign err_timeout = err_q;
    assign stall_if    = if_req & ~if_ready_q;
    assign stall_mem   = d_req & ~d_ready_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, hand sequences for ordering/timeout/reset, then random traffic
// against a transaction-level model of grants, completions, stalls and the sticky timeout flag.
module tb_mem_port_arbiter;
    localparam int MAXS = 4;
    localparam int TMO  = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, if_ready, d_req, d_we, d_ready;
    logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
    logic [3:0]  d_be, mem_be;
    logic        mem_req, mem_we, mem_ack, stall_if, stall_mem, err_timeout;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    mem_port_arbiter #(.MAX_D_STREAK(MAXS), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall_if(stall_if), .stall_mem(stall_mem), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: one outstanding transaction, then one bubble cycle before the next arbitration.
    bit          m_open = 0, m_cool = 0, m_err = 0, w_d = 0, w_chk_wd = 0;
    int          m_bcnt = 0, m_streak = 0;
    logic        w_we;
    logic [31:0] w_addr, w_wd;
    logic [3:0]  w_be;
    logic [31:0] grants[$];
    bit          prev_mem_req = 0, saw_ifr = 0, saw_dr = 0;

    // Memory responder knobs: ack in the ack_cyc-th busy cycle (0 = never), stray acks while idle.
    int          ack_cyc = 1, rcnt = 0;
    bit          rnd_lat = 0, stray = 0;
    logic [31:0] last_ack_dat = 32'h0;

    typedef struct {
        bit          port_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          ack_cyc;
        logic        exp_we;
        logic [3:0]  exp_be;
        int          exp_lat;
    } vec_t;
    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_fields(input string tag);
        chk({tag, "_mem_addr"}, mem_addr, w_addr);
        chk({tag, "_mem_we"}, mem_we, w_we);
        chk({tag, "_mem_be"}, mem_be, w_be);
        if (w_chk_wd) chk({tag, "_mem_wdata"}, mem_wdata, w_wd);
    endtask

    task automatic tick();
        logic        s_rst, s_if, s_d, s_we, s_ack;
        logic [31:0] s_ia, s_da, s_wd, s_ad, exp_rd;
        logic [3:0]  s_be;
        bit          e_ifr, e_dr;
        s_rst = reset; s_if = if_req; s_d = d_req; s_we = d_we; s_ack = mem_ack;
        s_ia = if_addr; s_da = d_addr; s_wd = d_wdata; s_be = d_be; s_ad = mem_rdata;
        @(posedge clk);
        #1;
        e_ifr = 0;
        e_dr  = 0;
        if (s_rst) begin
            m_open = 0; m_cool = 0; m_err = 0; m_streak = 0;
            chk("rst_mem_req", mem_req, 0);
            chk("rst_mem_we", mem_we, 0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_mem_wdata", mem_wdata, 0);
            chk("rst_mem_be", mem_be, 0);
            chk("rst_if_rdata", if_rdata, 0);
            chk("rst_d_rdata", d_rdata, 0);
        end else if (m_open && (s_ack || m_bcnt == TMO)) begin
            m_open = 0;
            m_cool = 1;
            exp_rd = s_ack ? s_ad : 32'h0;
            if (!s_ack) m_err = 1;
            if (w_d) begin
                e_dr = 1;
                if (!w_we) chk("d_rdata", d_rdata, exp_rd);
            end else begin
                e_ifr = 1;
                chk("if_rdata", if_rdata, exp_rd);
            end
            chk("mem_req_done", mem_req, 0);
        end else if (m_open) begin
            m_bcnt++;
            chk("mem_req_busy", mem_req, 1);
            chk_fields("busy");
        end else if (m_cool) begin
            m_cool = 0;
            chk("mem_req_bubble", mem_req, 0);
        end else if (s_if || s_d) begin
            w_d = s_d && !(s_if && m_streak == MAXS);
            if (w_d) begin
                w_we = s_we; w_addr = s_da; w_wd = s_wd; w_be = s_be; w_chk_wd = 1;
                m_streak = s_if ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
            end else begin
                w_we = 1'b0; w_addr = s_ia; w_be = 4'hF; w_chk_wd = 0;
                m_streak = 0;
            end
            m_open = 1;
            m_bcnt = 1;
            chk("mem_req_grant", mem_req, 1);
            chk_fields("grant");
        end else begin
            chk("mem_req_idle", mem_req, 0);
        end
        chk("if_ready", if_ready, e_ifr);
        chk("d_ready", d_ready, e_dr);
        chk("err_timeout", err_timeout, m_err);
        chk("stall_if", stall_if, s_if & ~e_ifr);
        chk("stall_mem", stall_mem, s_d & ~e_dr);

        if (mem_req && !prev_mem_req) grants.push_back(mem_addr);
        prev_mem_req = mem_req;
        saw_ifr = if_ready;
        saw_dr  = d_ready;

        if (mem_req) rcnt++; else rcnt = 0;
        if (rnd_lat && rcnt == 1) ack_cyc = ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, 6));
        mem_rdata = $urandom;
        mem_ack   = (mem_req && rcnt == ack_cyc) || (!mem_req && stray);
        if (mem_req && mem_ack) last_ack_dat = mem_rdata;
    endtask

    task automatic wait_ready(input bit port_d, input int limit, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!(port_d ? saw_dr : saw_ifr) && n < limit);
        chk("ready_within_bound", port_d ? saw_dr : saw_ifr, 1);
    endtask

    // One transaction from request to ready; returns request-to-ready latency in cycles.
    task automatic single(input bit port_d, output int lat);
        int n;
        tick();
        wait_ready(port_d, 60, n);
        lat = 1 + n;
    endtask

    task automatic new_d();
        d_we    = 1'($urandom_range(0, 1));
        d_addr  = $urandom & 32'hFFFF_FFFC;
        d_wdata = $urandom;
        d_be    = 4'($urandom_range(0, 15));
    endtask

    task automatic agents_random();
        if (saw_ifr) begin
            if_req  = ($urandom_range(0, 1) == 1);
            if_addr = $urandom & 32'hFFFF_FFFC;
        end else if (!if_req) begin
            if ($urandom_range(0, 2) == 0) begin
                if_req  = 1'b1;
                if_addr = $urandom & 32'hFFFF_FFFC;
            end
        end else if ($urandom_range(0, 99) == 0) begin
            if_req = 1'b0;
        end
        if (saw_dr) begin
            d_req = ($urandom_range(0, 1) == 1);
            new_d();
        end else if (!d_req) begin
            if ($urandom_range(0, 2) != 0) begin
                d_req = 1'b1;
                new_d();
            end
        end else if ($urandom_range(0, 99) == 0) begin
            d_req = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, n, ni, nd;
        bit if_done, d_done;
        logic [31:0] exp_a;

        vecs[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         4'h0,    1, 1'b0, 4'hF,    2};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_0200, 32'h0,         4'hF,    1, 1'b0, 4'hF,    2};
        vecs[2] = '{1'b1, 1'b1, 32'h0000_0204, 32'hCAFE_F00D, 4'b1001, 3, 1'b1, 4'b1001, 4};
        vecs[3] = '{1'b0, 1'b1, 32'h0000_0044, 32'h0000_1234, 4'h1,    2, 1'b0, 4'hF,    3};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_03FC, 32'h0,         4'b0110, 5, 1'b0, 4'b0110, 6};
        vecs[5] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0,    4, 1'b0, 4'hF,    5};

        reset = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; d_be = '0; mem_rdata = '0; mem_ack = 1'b0;
        tick();
        tick();
        chk("reset_err_timeout", err_timeout, 0);
        reset = 1'b0;
        tick();

        // Vector table; stray acks in idle/bubble cycles must be ignored throughout.
        stray = 1;
        for (int i = 0; i < 6; i++) begin
            ack_cyc = vecs[i].ack_cyc;
            d_we = vecs[i].we; d_wdata = vecs[i].wdata; d_be = vecs[i].be;
            d_addr = vecs[i].addr; if_addr = vecs[i].addr;
            if (vecs[i].port_d) d_req = 1'b1; else if_req = 1'b1;
            tick();
            chk("vec_mem_addr", mem_addr, vecs[i].addr);
            chk("vec_mem_we", mem_we, vecs[i].exp_we);
            chk("vec_mem_be", mem_be, vecs[i].exp_be);
            wait_ready(vecs[i].port_d, 60, n);
            chk("vec_latency", 1 + n, vecs[i].exp_lat);
            if (vecs[i].port_d && !vecs[i].we) chk("vec_d_rdata", d_rdata, last_ack_dat);
            if (!vecs[i].port_d) chk("vec_if_rdata", if_rdata, last_ack_dat);
            if_req = 1'b0;
            d_req  = 1'b0;
            tick();
            tick();
            tick();
        end
        stray = 0;

        // Simultaneous requests: data store first, then fetch after one bubble.
        grants.delete();
        ack_cyc = 2;
        if_addr = 32'h80; if_req = 1'b1;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_be = 4'b0011;
        tick();
        chk("t2_mem_we", mem_we, 1);
        chk("t2_mem_addr", mem_addr, 32'h100);
        chk("t2_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("t2_mem_be", mem_be, 4'b0011);
        chk("t2_stall_if_first", stall_if, 1);
        if_done = 0;
        d_done  = 0;
        for (int c = 0; c < 30 && !if_done; c++) begin
            tick();
            if (!d_done) chk("t2_stall_if", stall_if, 1);
            if (saw_dr) begin d_req = 1'b0; d_done = 1; end
            if (saw_ifr) begin if_req = 1'b0; if_done = 1; end
        end
        chk("t2_if_done", if_done, 1);
        chk("t2_grant_count", grants.size(), 2);
        if (grants.size() == 2) begin
            chk("t2_first_grant", grants[0], 32'h100);
            chk("t2_second_grant", grants[1], 32'h80);
        end
        tick();

        // Both ports saturated: every fifth grant goes to fetch.
        grants.delete();
        ack_cyc = 1;
        if_addr = 32'h1000; d_addr = 32'h2000; d_we = 1'b0; d_be = 4'hF;
        if_req = 1'b1; d_req = 1'b1;
        for (int c = 0; c < 300 && grants.size() < 10; c++) begin
            tick();
            if (saw_ifr) if_addr = if_addr + 32'd4;
            if (saw_dr) d_addr = d_addr + 32'd4;
        end
        chk("t3_grant_count", grants.size(), 10);
        wait_ready(0, 20, n);
        if_req = 1'b0;
        d_req  = 1'b0;
        tick();
        tick();
        ni = 0;
        nd = 0;
        for (int g = 0; g < 10 && g < grants.size(); g++) begin
            if (g % (MAXS + 1) == MAXS) begin
                exp_a = 32'h1000 + 32'(4 * ni);
                ni++;
            end else begin
                exp_a = 32'h2000 + 32'(4 * nd);
                nd++;
            end
            chk("t3_grant_order", grants[g], exp_a);
        end

        // Hung memory: abort after TMO busy cycles, flag stays set until reset.
        ack_cyc = 0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
        single(1, lat);
        chk("t4_timeout_latency", lat, TMO + 1);
        chk("t4_d_rdata_zero", d_rdata, 0);
        chk("t4_err_set", err_timeout, 1);
        d_req = 1'b0;
        ack_cyc = 1;
        tick();
        if_req = 1'b1; if_addr = 32'h40;
        single(0, lat);
        chk("t4_good_latency", lat, 2);
        chk("t4_if_rdata", if_rdata, last_ack_dat);
        chk("t4_err_sticky", err_timeout, 1);
        if_req = 1'b0;
        tick();

        // Reset while a store is in flight drops it silently.
        ack_cyc = 0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h500; d_wdata = 32'h5555_AAAA; d_be = 4'hF;
        tick();
        tick();
        tick();
        chk("t5_busy_before_reset", mem_req, 1);
        reset = 1'b1;
        d_req = 1'b0;
        tick();
        chk("t5_mem_req_at_reset", mem_req, 0);
        chk("t5_err_cleared", err_timeout, 0);
        reset = 1'b0;
        ack_cyc = 1;
        n = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (saw_dr) n++;
        end
        chk("t5_no_d_ready", n, 0);
        if_req = 1'b1; if_addr = 32'h60;
        single(0, lat);
        chk("t5_if_latency", lat, 2);
        chk("t5_if_rdata", if_rdata, last_ack_dat);
        if_req = 1'b0;
        tick();

        // Random traffic with random ack latency, occasional timeouts and stray acks.
        rnd_lat = 1;
        for (int c = 0; c < 4000; c++) begin
            tick();
            agents_random();
            stray = ($urandom_range(0, 1) == 1);
        end
        rnd_lat = 0;
        ack_cyc = 1;
        stray   = 0;
        if_req  = 1'b0;
        d_req   = 1'b0;
        for (int c = 0; c < 40; c++) tick();
        chk("final_idle", mem_req, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
